// File: rtl/bram_fifo_drain_sched_if.sv
// Registered output stream of the BRAM FIFO drain scheduler.
// master drives the word; slave is the downstream consumer.
interface bram_fifo_drain_sched_if #(
   parameter int unsigned W    = 32,
   parameter int unsigned IDXW = 2
);
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [IDXW-1:0] out_src;
   logic            out_last;
   logic            out_ready;

   modport master (
      output out_valid,
      output out_data,
      output out_src,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_src,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/bram_fifo_drain_sched.sv
// Round-robin drain of NQ first-word-fall-through BRAM FIFOs into one registered
// valid/ready stream, holding each grant for a burst of up to MAX_BURST words.
module bram_fifo_drain_sched #(
   parameter int unsigned NQ        = 4,
   parameter int unsigned W         = 32,
   parameter int unsigned IDXW      = 2,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned BW        = 4
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CLR,
   input  logic [NQ-1:0]       src_en,
   input  logic [NQ-1:0]       src_empty_n,
   input  logic [NQ*W-1:0]     src_data,
   output logic [NQ-1:0]       src_deq,
   bram_fifo_drain_sched_if.master dn
);

   typedef enum logic {StIdle, StBurst} state_e;

   state_e          state_q, state_d;
   logic [IDXW-1:0] cur_q, cur_d;
   logic [IDXW-1:0] last_q, last_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [IDXW-1:0] out_src_q, out_src_d;
   logic            out_last_q, out_last_d;

   logic            clr;
   logic [NQ-1:0]   req;
   logic            slot_free;
   logic            beat_end;
   logic            pop;
   logic            found;
   logic [IDXW-1:0] pick;
   int unsigned     rr_idx;

   assign clr       = !RST_N || CLR;
   assign req       = src_empty_n & src_en;
   assign slot_free = !out_valid_q || dn.out_ready;
   assign beat_end  = (beat_q == BW'(MAX_BURST - 1));

   // Search starts just after the last granted queue and wraps.
   always_comb begin
      pick   = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int unsigned i = 1; i <= NQ; i++) begin
         rr_idx = (32'(last_q) + i) % NQ;
         if (!found && req[IDXW'(rr_idx)]) begin
            pick  = IDXW'(rr_idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      beat_d      = beat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_last_d  = out_last_q;
      pop         = 1'b0;
      src_deq     = '0;

      if (out_valid_q && dn.out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (found) begin
               cur_d   = pick;
               beat_d  = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (slot_free) begin
               pop = src_empty_n[cur_q] && src_en[cur_q];
               if (pop) begin
                  src_deq[cur_q] = 1'b1;
                  out_valid_d    = 1'b1;
                  out_data_d     = src_data[32'(cur_q) * W +: W];
                  out_src_d      = cur_q;
                  out_last_d     = beat_end;
                  beat_d         = beat_q + 1'b1;
                  if (beat_end) begin
                     state_d = StIdle;
                     last_d  = cur_q;
                  end
               end else begin
                  // Empty (or just disabled) queue ends the grant early.
                  state_d = StIdle;
                  last_d  = cur_q;
               end
            end
         end
      endcase

      if (clr) begin
         src_deq = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (clr) begin
         state_q     <= StIdle;
         cur_q       <= '0;
         last_q      <= IDXW'(NQ - 1);
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
      end
   end

   assign dn.out_valid = out_valid_q;
   assign dn.out_data  = out_data_q;
   assign dn.out_src   = out_src_q;
   assign dn.out_last  = out_last_q;

   a_deq_onehot: assert property (@(posedge CLK) disable iff (clr) $onehot0(src_deq));

   a_deq_nonempty: assert property (@(posedge CLK) disable iff (clr)
      (src_deq & ~src_empty_n) == '0);

   a_out_stable: assert property (@(posedge CLK) disable iff (clr)
      (out_valid_q && !dn.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_src_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_bram_fifo_drain_sched.sv
// Scoreboard bench for bram_fifo_drain_sched: behavioural FIFO models feed the DUT,
// expected words are queued as stimulus is loaded and compared on each handshake.
module tb_bram_fifo_drain_sched;
   localparam int NQ   = 4;
   localparam int W    = 32;
   localparam int IDXW = 2;
   localparam int MAXB = 4;
   localparam int BW   = 4;

   typedef struct packed {
      logic [IDXW-1:0] src;
      logic            last;
      logic [W-1:0]    data;
   } exp_t;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic            CLR;
   logic [NQ-1:0]   src_en;
   logic [NQ-1:0]   src_empty_n;
   logic [NQ*W-1:0] src_data;
   logic [NQ-1:0]   src_deq;

   bram_fifo_drain_sched_if #(.W(W), .IDXW(IDXW)) dn ();

   bram_fifo_drain_sched #(
      .NQ(NQ), .W(W), .IDXW(IDXW), .MAX_BURST(MAXB), .BW(BW)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .CLR(CLR),
      .src_en(src_en),
      .src_empty_n(src_empty_n),
      .src_data(src_data),
      .src_deq(src_deq),
      .dn(dn)
   );

   always #5 CLK = ~CLK;

   logic [W-1:0]    fifo [NQ][$];
   exp_t            sb [$];
   int              xfer_cyc [$];
   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              nxfer = 0;
   logic [NQ-1:0]   deq_hist;
   logic [NQ-1:0]   s_deq;
   logic            s_valid;
   logic            s_last;
   logic [W-1:0]    s_data;
   logic [IDXW-1:0] s_src;

   task automatic refresh();
      for (int i = 0; i < NQ; i++) begin
         src_empty_n[i]     = (fifo[i].size() != 0);
         src_data[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
      end
   endtask

   task automatic load(input int q, input int n, input logic [7:0] tag);
      for (int k = 0; k < n; k++) fifo[q].push_back({8'(q), tag, 16'(k)});
      refresh();
   endtask

   // Sample at the falling edge, then apply the FIFO pops that edge committed.
   task automatic tick();
      exp_t          e;
      logic [NQ-1:0] snap;
      @(negedge CLK);
      snap     = src_deq;
      s_deq    = src_deq;
      s_valid  = dn.out_valid;
      s_data   = dn.out_data;
      s_src    = dn.out_src;
      s_last   = dn.out_last;
      deq_hist = deq_hist | snap;
      checks++;
      if (((snap & (snap - 1'b1)) !== '0) || ((snap & ~src_empty_n) !== '0)) begin
         errors++;
         $display("FAIL deq_legal: src_deq=%b src_empty_n=%b, required one-hot/zero on non-empty",
                  snap, src_empty_n);
      end
      if (s_valid === 1'b1 && dn.out_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got src=%0d data=%h, required no word", s_src, s_data);
         end else begin
            e = sb.pop_front();
            if ({s_src, s_last, s_data} !== e) begin
               errors++;
               $display("FAIL xfer: got src=%0d last=%0b data=%h, required src=%0d last=%0b data=%h",
                        s_src, s_last, s_data, e.src, e.last, e.data);
            end
         end
         xfer_cyc.push_back(cyc);
         nxfer++;
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < NQ; i++) if (snap[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
      cyc++;
      refresh();
   endtask

   task automatic build_expected(input int start, input logic [NQ-1:0] en);
      int   cnt [NQ];
      int   pos [NQ];
      int   left;
      int   ptr;
      int   n;
      exp_t e;
      left = 0;
      for (int i = 0; i < NQ; i++) begin
         cnt[i] = en[i] ? fifo[i].size() : 0;
         pos[i] = 0;
         left += cnt[i];
      end
      ptr = start;
      while (left > 0) begin
         if (cnt[ptr] > 0) begin
            n = (cnt[ptr] > MAXB) ? MAXB : cnt[ptr];
            for (int k = 0; k < n; k++) begin
               e.src  = IDXW'(ptr);
               e.last = (k == MAXB - 1);
               e.data = fifo[ptr][pos[ptr]];
               sb.push_back(e);
               pos[ptr]++;
            end
            cnt[ptr] -= n;
            left     -= n;
         end
         ptr = (ptr + 1) % NQ;
      end
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && sb.size() != 0; i++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d words still outstanding, required 0", sb.size());
      end
      repeat (4) tick();
   endtask

   task automatic do_reset();
      RST_N        = 1'b0;
      CLR          = 1'b0;
      src_en       = '1;
      dn.out_ready = 1'b0;
      for (int i = 0; i < NQ; i++) fifo[i].delete();
      refresh();
      repeat (2) tick();
      RST_N        = 1'b1;
      dn.out_ready = 1'b1;
      cyc          = 0;
      nxfer        = 0;
      deq_hist     = '0;
      sb.delete();
      xfer_cyc.delete();
   endtask

   task automatic test_reset();
      load(0, 3, 8'hA0);
      repeat (3) tick();
      checks++;
      if (s_deq !== '0) begin
         errors++;
         $display("FAIL reset_deq: src_deq=%b, required 0", s_deq);
      end
      checks++;
      if (dn.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: out_valid=%b, required 0", dn.out_valid);
      end
      checks++;
      if (dn.out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: out_data=%h, required 0", dn.out_data);
      end
      checks++;
      if (dn.out_src !== '0 || dn.out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_src_last: out_src=%0d out_last=%b, required 0/0",
                  dn.out_src, dn.out_last);
      end
   endtask

   task automatic test_single_queue();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.src = '0; e.last = 1'b0; e.data = fifo[0][k];
         sb.push_back(e);
      end
      dn.out_ready = 1'b1;
      RST_N        = 1'b1;
      cyc          = 0;
      nxfer        = 0;
      xfer_cyc.delete();
      for (int i = 0; i < 20 && nxfer < 3; i++) tick();
      checks++;
      if (xfer_cyc.size() != 3) begin
         errors++;
         $display("FAIL single_count: %0d words, required 3", xfer_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (xfer_cyc[k] != 2 + k) begin
               errors++;
               $display("FAIL single_latency: word %0d at cycle %0d, required %0d",
                        k, xfer_cyc[k], 2 + k);
            end
         end
      end
      repeat (3) tick();
      // Queue 0 was granted last, so queue 1 must win when both arrive together.
      load(1, 1, 8'hB1);
      load(0, 1, 8'hB0);
      e.src = 2'd1; e.last = 1'b0; e.data = fifo[1][0];
      sb.push_back(e);
      e.src = 2'd0; e.last = 1'b0; e.data = fifo[0][0];
      sb.push_back(e);
      drain(20);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int q = 0; q < NQ; q++) load(q, 10, 8'hC0 + 8'(q));
      build_expected(0, '1);
      drain(200);
      checks++;
      if (nxfer != 40 || xfer_cyc.size() < 5) begin
         errors++;
         $display("FAIL rr_count: %0d words, required 40", nxfer);
      end else begin
         checks++;
         if (xfer_cyc[1] - xfer_cyc[0] != 1) begin
            errors++;
            $display("FAIL rr_in_burst_gap: %0d cycles, required 1", xfer_cyc[1] - xfer_cyc[0]);
         end
         checks++;
         if (xfer_cyc[4] - xfer_cyc[3] != 2) begin
            errors++;
            $display("FAIL rr_bubble: %0d cycles, required 2", xfer_cyc[4] - xfer_cyc[3]);
         end
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] held;
      held = '0;
      do_reset();
      load(2, 6, 8'hD2);
      build_expected(0, '1);
      for (int i = 0; i < 20 && nxfer < 1; i++) tick();
      checks++;
      if (nxfer < 1) begin
         errors++;
         $display("FAIL stall_start: %0d words, required 1", nxfer);
      end
      dn.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (s_valid !== 1'b1 || s_deq !== '0 || s_src !== 2'd2) begin
            errors++;
            $display("FAIL stall_hold: valid=%b deq=%b src=%0d, required 1/0000/2",
                     s_valid, s_deq, s_src);
         end
         checks++;
         if (i == 0) begin
            held = s_data;
            if (sb.size() == 0 || s_data !== sb[0].data) begin
               errors++;
               $display("FAIL stall_word: data=%h, required next queued word", s_data);
            end
         end else if (s_data !== held) begin
            errors++;
            $display("FAIL stall_data: data=%h, required %h", s_data, held);
         end
      end
      dn.out_ready = 1'b1;
      drain(50);
   endtask

   task automatic test_src_en();
      do_reset();
      src_en = 4'b1010;
      for (int q = 0; q < NQ; q++) load(q, 6, 8'hE0 + 8'(q));
      build_expected(0, 4'b1010);
      drain(100);
      checks++;
      if (deq_hist[0] !== 1'b0 || deq_hist[2] !== 1'b0) begin
         errors++;
         $display("FAIL en_deq: deq history=%b, required bits 0 and 2 clear", deq_hist);
      end
      checks++;
      if (fifo[0].size() != 6 || fifo[2].size() != 6) begin
         errors++;
         $display("FAIL en_untouched: q0=%0d q2=%0d words, required 6/6",
                  fifo[0].size(), fifo[2].size());
      end
   endtask

   task automatic test_empty_midburst();
      exp_t e;
      logic refilled;
      refilled = 1'b0;
      do_reset();
      load(1, 2, 8'hE1);
      load(2, 3, 8'hE2);
      for (int k = 0; k < 2; k++) begin
         e.src = 2'd1; e.last = 1'b0; e.data = fifo[1][k];
         sb.push_back(e);
      end
      for (int k = 0; k < 3; k++) begin
         e.src = 2'd2; e.last = 1'b0; e.data = fifo[2][k];
         sb.push_back(e);
      end
      e.src = 2'd1; e.last = 1'b0; e.data = {8'd1, 8'hE1, 16'd2};
      sb.push_back(e);
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         tick();
         // Refill queue 1 once the scheduler has dropped back to idle.
         if (!refilled && fifo[1].size() == 0) begin
            tick();
            fifo[1].push_back({8'd1, 8'hE1, 16'd2});
            refresh();
            refilled = 1'b1;
         end
      end
      checks++;
      if (sb.size() != 0 || !refilled) begin
         errors++;
         $display("FAIL midburst: %0d words outstanding, refilled=%b, required 0/1",
                  sb.size(), refilled);
      end
      repeat (4) tick();
   endtask

   task automatic test_clr();
      do_reset();
      load(2, 1, 8'hF2);
      load(3, 8, 8'hF3);
      build_expected(0, '1);
      for (int i = 0; i < 30 && nxfer < 2; i++) tick();
      checks++;
      if (nxfer < 2) begin
         errors++;
         $display("FAIL clr_start: %0d words, required 2", nxfer);
      end
      load(0, 2, 8'hF0);
      CLR = 1'b1;
      tick();
      checks++;
      if (s_deq !== '0) begin
         errors++;
         $display("FAIL clr_deq: src_deq=%b, required 0", s_deq);
      end
      CLR = 1'b0;
      tick();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_valid: out_valid=%b, required 0", s_valid);
      end
      sb.delete();
      build_expected(0, '1);
      drain(60);
   endtask

   initial begin
      RST_N        = 1'b0;
      CLR          = 1'b0;
      src_en       = '1;
      dn.out_ready = 1'b0;
      deq_hist     = '0;
      refresh();
      test_reset();
      test_single_queue();
      test_round_robin();
      test_stall();
      test_src_en();
      test_empty_midburst();
      test_clr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
